ram_bist_ctrl: RTL and testbench
================================

Name: ram_bist_ctrl

Overview:
- Built-in self-test controller that sits directly upstream of the 1024x8 single-port RAM (ram_3).
- Drives the RAM's addr, data_in, wr, cs and rd pins, and consumes its data_out.
- Runs two write-then-verify passes over the whole array: a true pattern, then an inverted pattern.
- Reports pass/fail, the first failing location, and a saturating error count.

Parameters:
- ADDR_W, 10, RAM address width.
- DATA_W, 8, RAM data width.
- DEPTH, 1024, number of RAM words tested (addresses 0..DEPTH-1).
- ERR_W, 16, width of the error counter.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a test run.
- mem_addr  out  ADDR_W  address to RAM addr.
- mem_data_in  out  DATA_W  write data to RAM data_in.
- mem_wr  out  1  RAM write strobe, active-high.
- mem_cs  out  1  RAM chip select, active-high.
- mem_rd  out  1  RAM read strobe, active-high.
- mem_data_out  in  DATA_W  read data from RAM data_out.
- busy  out  1  high while a run is in progress.
- done  out  1  high from run completion until the next accepted start or reset.
- pass  out  1  valid while done=1; 1 means zero mismatches.
- fail_addr  out  ADDR_W  address of the first mismatch.
- fail_exp  out  DATA_W  expected data at the first mismatch.
- fail_act  out  DATA_W  actual data at the first mismatch.
- err_count  out  ERR_W  total mismatches, saturating.

Behaviour:
- Reset: state=IDLE. All outputs are 0: mem_*, busy, done, pass, fail_*, err_count.
- Patterns:
  - Pass A expected data = (2*addr) mod 2^DATA_W.
  - Pass B expected data = bitwise NOT of the pass-A value.
- FSM states: IDLE, WR, RD_ISSUE, RD_CMP, DONE.
- IDLE / DONE:
  - A start accepted in either state clears err_count, fail_* and pass, and drops done.
  - The cycle after start: state=WR, pass_sel=A, addr=0, busy=1.
- WR:
  - Each cycle drives mem_cs=1, mem_wr=1, mem_rd=0, mem_addr=addr, mem_data_in=pattern(addr). One write per cycle.
  - At addr=DEPTH-1, addr wraps to 0 and state goes to RD_ISSUE. Otherwise addr increments.
- RD_ISSUE: drives mem_cs=1, mem_rd=1, mem_wr=0, mem_addr=addr, then goes to RD_CMP.
- RD_CMP:
  - Holds mem_cs=1, mem_rd=1, mem_addr=addr, and samples mem_data_out this cycle.
  - On mismatch, err_count increments, saturating at 2^ERR_W-1.
  - If this is the first mismatch of the run, fail_addr, fail_exp and fail_act are captured. Later mismatches never overwrite them.
  - If addr<DEPTH-1: addr increments and state returns to RD_ISSUE.
  - If addr=DEPTH-1 and pass_sel=A: pass_sel=B, addr=0, state=WR.
  - If addr=DEPTH-1 and pass_sel=B: state=DONE.
- Run latency: exactly 6*DEPTH cycles from the first WR cycle to entering DONE (6144 at default).
- On entering DONE: busy=0, done=1, pass=(err_count==0). mem_cs, mem_wr and mem_rd are 0.
- Strobes:
  - mem_wr and mem_rd are never high in the same cycle.
  - mem_cs=0 whenever the controller is in IDLE or DONE.
- start while busy=1 is ignored; there is no restart and no effect on counters.
- rst asserted mid-run: the next cycle is IDLE with all outputs at reset values. RAM contents are don't-care.
- The first-fail capture and the err_count increment occur in the same cycle when the first mismatch is found.

Decomposition:
- Shared package ram_bist_pkg holds:
  - the state enum (IDLE, WR, RD_ISSUE, RD_CMP, DONE);
  - the pass_sel encoding (PASS_A=0, PASS_B=1);
  - default width constants;
  - the pattern function pattern(addr, pass_sel).
- Natural sub-module: ram_bist_pattern, a combinational expected-data generator. It is shared by the write and compare paths so both use identical data.
- The top level holds the FSM, address counter, error counter and capture registers.

Test Plan:
- Ideal RAM model, start pulse -> busy high for 6144 cycles, then done=1, pass=1, err_count=0, fail_* all 0.
- RAM model with bit0 of addr 5 stuck-at-1 -> pass=0, err_count=1, fail_addr=5, fail_exp=0x0A, fail_act=0x0B. Pass B expects odd data there, so it sees no error.
- RAM model returning 0 on every read -> err_count=2040 (1016 in pass A, where addrs 0,128,...,896 match; 1024 in pass B), fail_addr=1, fail_exp=0x02, fail_act=0x00.
- start pulsed again at cycle 100 of a run -> ignored; completion still at cycle 6144 with identical results.
- rst asserted during pass B read phase, then start -> outputs return to 0 the next cycle, and the fresh run completes in 6144 cycles with pass=1.
- Strobe check across a full run (assertion) -> mem_wr&mem_rd never both 1; mem_cs=0 in IDLE/DONE; first write is addr 0 data 0x00; first pass-B write is addr 0 data 0xFF.

Source files
------------

// File: rtl/ram_bist_pkg.sv
// Shared definitions for the RAM BIST controller: FSM states, pass selector,
// default widths and the reference test-pattern function.
package ram_bist_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 1024;
    localparam int DEF_ERR_W  = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR       = 3'd1,
        RD_ISSUE = 3'd2,
        RD_CMP   = 3'd3,
        DONE     = 3'd4
    } state_e;

    typedef enum logic {
        PASS_A = 1'b0,
        PASS_B = 1'b1
    } pass_sel_e;

    // Pass A writes (2*addr) mod 2^DATA_W; pass B writes its bitwise inverse.
    function automatic logic [DEF_DATA_W-1:0] pattern(input logic [DEF_ADDR_W-1:0] addr,
                                                      input pass_sel_e          sel);
        logic [DEF_DATA_W-1:0] base;
        base = DEF_DATA_W'({addr, 1'b0});
        return (sel == PASS_B) ? ~base : base;
    endfunction

endpackage

// File: rtl/ram_bist_pattern.sv
// Combinational expected-data generator. One instance feeds both the write
// data path and the read comparator so the two can never disagree.
module ram_bist_pattern
    import ram_bist_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  pass_sel_e         sel_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] base;

    // Doubling is a left shift by one; the size cast keeps the low DATA_W bits.
    assign base   = DATA_W'({addr_i, 1'b0});
    assign data_o = (sel_i == PASS_B) ? ~base : base;

endmodule

// File: rtl/ram_bist_ctrl.sv
// RAM BIST controller: two write-then-verify passes (true pattern, then the
// inverted pattern) over the whole array, with first-fail capture and a
// saturating mismatch counter.
//
// Handshake: start is a single-cycle request, accepted only while the FSM is
// in IDLE or DONE; it is silently ignored while busy=1. The RAM is assumed to
// have a registered read port: data addressed in RD_ISSUE is on mem_data_out
// during RD_CMP, where it is compared.
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ERR_W  = DEF_ERR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_wr,
    output logic              mem_cs,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_act,
    output logic [ERR_W-1:0]  err_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

    state_e            state_q,     state_d;
    pass_sel_e         sel_q,       sel_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [ERR_W-1:0]  err_q,       err_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_exp_q,  fail_exp_d;
    logic [DATA_W-1:0] fail_act_q,  fail_act_d;

    logic [DATA_W-1:0] exp_data;
    logic              active;
    logic              mismatch;

    ram_bist_pattern #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_pattern (
        .addr_i (addr_q),
        .sel_i  (sel_q),
        .data_o (exp_data)
    );

    assign mismatch = (mem_data_out != exp_data);

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= PASS_A;
            addr_q      <= '0;
            err_q       <= '0;
            fail_addr_q <= '0;
            fail_exp_q  <= '0;
            fail_act_q  <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            err_q       <= err_d;
            fail_addr_q <= fail_addr_d;
            fail_exp_q  <= fail_exp_d;
            fail_act_q  <= fail_act_d;
        end
    end

    // Next-state logic: address sweep, pass sequencing, compare and capture.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        err_d       = err_q;
        fail_addr_d = fail_addr_q;
        fail_exp_d  = fail_exp_q;
        fail_act_d  = fail_act_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = WR;
                    sel_d       = PASS_A;
                    addr_d      = '0;
                    err_d       = '0;
                    fail_addr_d = '0;
                    fail_exp_d  = '0;
                    fail_act_d  = '0;
                end
            end
            WR: begin
                if (addr_q == LAST_ADDR) begin
                    addr_d  = '0;
                    state_d = RD_ISSUE;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            RD_ISSUE: begin
                state_d = RD_CMP;
            end
            RD_CMP: begin
                if (mismatch) begin
                    // A zero count means no mismatch yet this run (it saturates, never wraps).
                    if (err_q == '0) begin
                        fail_addr_d = addr_q;
                        fail_exp_d  = exp_data;
                        fail_act_d  = mem_data_out;
                    end
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + 1'b1;
                    end
                end
                if (addr_q != LAST_ADDR) begin
                    addr_d  = addr_q + 1'b1;
                    state_d = RD_ISSUE;
                end else if (sel_q == PASS_A) begin
                    sel_d   = PASS_B;
                    addr_d  = '0;
                    state_d = WR;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode: the RAM is only selected while a run is active.
    always_comb begin
        active      = (state_q == WR) || (state_q == RD_ISSUE) || (state_q == RD_CMP);
        busy        = active;
        done        = (state_q == DONE);
        pass        = done && (err_q == '0);
        mem_cs      = active;
        mem_wr      = (state_q == WR);
        mem_rd      = (state_q == RD_ISSUE) || (state_q == RD_CMP);
        mem_addr    = active ? addr_q : '0;
        mem_data_in = (state_q == WR) ? exp_data : '0;
        fail_addr   = fail_addr_q;
        fail_exp    = fail_exp_q;
        fail_act    = fail_act_q;
        err_count   = err_q;
    end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Self-checking bench for ram_bist_ctrl: a fault-injectable RAM model, a
// result scoreboard fed by a pattern/fault reference model, and a per-cycle
// monitor of the RAM strobes and write stream.
module tb_ram_bist_ctrl;

    localparam int ADDR_W      = 10;
    localparam int DATA_W      = 8;
    localparam int DEPTH       = 1024;
    localparam int ERR_W       = 16;
    localparam int PASS_CYCLES = 3 * DEPTH;
    localparam int RUN_CYCLES  = 6 * DEPTH;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_wr;
    logic              mem_cs;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_data_out = '0;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ADDR_W-1:0] fail_addr;
    logic [DATA_W-1:0] fail_exp;
    logic [DATA_W-1:0] fail_act;
    logic [ERR_W-1:0]  err_count;

    int n_checks = 0;
    int n_fail   = 0;

    // RAM array plus per-address read fault masks: read = (stored & and_m) | or_m.
    logic [DATA_W-1:0] ram  [DEPTH];
    logic [DATA_W-1:0] and_m[DEPTH];
    logic [DATA_W-1:0] or_m [DEPTH];

    // Expected run result packed as {pass, err_count, fail_addr, fail_exp, fail_act}.
    logic [42:0] exp_q[$];

    int   busy_cnt  = 0;
    logic busy_prev = 1'b0;
    logic done_prev = 1'b0;

    ram_bist_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_wr       (mem_wr),
        .mem_cs       (mem_cs),
        .mem_rd       (mem_rd),
        .mem_data_out (mem_data_out),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .fail_addr    (fail_addr),
        .fail_exp     (fail_exp),
        .fail_act     (fail_act),
        .err_count    (err_count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- RAM model (registered read) ----------------
    always @(posedge clk) begin
        if (mem_cs && mem_wr) ram[mem_addr] <= mem_data_in;
        if (mem_cs && mem_rd) mem_data_out <= (ram[mem_addr] & and_m[mem_addr]) | or_m[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Walks both passes over the array: what was written, what the faulty RAM
    // returns, and how the first mismatch and the count come out.
    function automatic logic [42:0] model_result();
        int               err;
        logic [ADDR_W-1:0] fa;
        logic [DATA_W-1:0] fe, fr, e, r;
        err = 0; fa = '0; fe = '0; fr = '0;
        for (int p = 0; p < 2; p++) begin
            for (int a = 0; a < DEPTH; a++) begin
                e = DATA_W'((2 * a) % 256);
                if (p == 1) e = ~e;
                r = (e & and_m[a]) | or_m[a];
                if (r != e) begin
                    if (err == 0) begin
                        fa = ADDR_W'(a);
                        fe = e;
                        fr = r;
                    end
                    if (err < 65535) err++;
                end
            end
        end
        return {(err == 0), 16'(err), fa, fe, fr};
    endfunction

    task automatic clear_faults();
        for (int i = 0; i < DEPTH; i++) begin
            and_m[i] = '1;
            or_m[i]  = '0;
        end
    endtask

    task automatic random_faults();
        int n, a, b;
        clear_faults();
        n = $urandom_range(1, 6);
        for (int k = 0; k < n; k++) begin
            a = $urandom_range(0, DEPTH - 1);
            b = $urandom_range(0, DATA_W - 1);
            if ($urandom_range(0, 1) == 1) and_m[a][b] = 1'b0;
            else                           or_m[a][b]  = 1'b1;
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        int               ph;
        logic [DATA_W-1:0] e;
        logic [42:0]       x;
        if (busy) begin
            if (!busy_prev) busy_cnt = 1;
            else            busy_cnt++;
        end

        check("wr_rd_exclusive", 32'(mem_wr & mem_rd), 0);
        if (!busy) check("cs_low_when_idle", 32'(mem_cs), 0);

        if (busy) begin
            ph = (busy_cnt - 1) % PASS_CYCLES;
            check("wr_phase", 32'(mem_wr), 32'(ph < DEPTH));
            if (mem_wr) begin
                e = DATA_W'((2 * int'(mem_addr)) % 256);
                if (busy_cnt > PASS_CYCLES) e = ~e;
                check("wr_addr", 32'(mem_addr), ph);
                check("wr_data", 32'(mem_data_in), 32'(e));
            end else begin
                check("rd_strobe", 32'(mem_rd & mem_cs), 1);
                check("rd_addr", 32'(mem_addr), (ph - DEPTH) / 2);
            end
            if (busy_cnt == 1) begin
                check("first_wr_a_addr", 32'(mem_addr), 0);
                check("first_wr_a_data", 32'(mem_data_in), 32'h00);
            end
            if (busy_cnt == PASS_CYCLES + 1) begin
                check("first_wr_b_addr", 32'(mem_addr), 0);
                check("first_wr_b_data", 32'(mem_data_in), 32'hFF);
            end
        end

        if (done && !done_prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 0);
            end else begin
                x = exp_q.pop_front();
                check("latency", busy_cnt, RUN_CYCLES);
                check("pass", 32'(pass), 32'(x[42]));
                check("err_count", 32'(err_count), 32'(x[41:26]));
                check("fail_addr", 32'(fail_addr), 32'(x[25:16]));
                check("fail_exp", 32'(fail_exp), 32'(x[15:8]));
                check("fail_act", 32'(fail_act), 32'(x[7:0]));
            end
        end
        busy_prev = busy;
        done_prev = done;
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_pass"}, 32'(pass), 0);
        check({tag, "_err_count"}, 32'(err_count), 0);
        check({tag, "_fail_addr"}, 32'(fail_addr), 0);
        check({tag, "_fail_exp"}, 32'(fail_exp), 0);
        check({tag, "_fail_act"}, 32'(fail_act), 0);
        check({tag, "_mem_cs"}, 32'(mem_cs), 0);
        check({tag, "_mem_wr"}, 32'(mem_wr), 0);
        check({tag, "_mem_rd"}, 32'(mem_rd), 0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 0);
        check({tag, "_mem_data_in"}, 32'(mem_data_in), 0);
    endtask

    // Full run: predict, start, optionally poke start mid-run, await done.
    task automatic run(input bit extra_start);
        bit got;
        exp_q.push_back(model_result());
        pulse_start();
        check("started_busy", 32'(busy), 1);
        check("started_done", 32'(done), 0);
        check("started_pass", 32'(pass), 0);
        check("started_err_count", 32'(err_count), 0);
        check("started_fail_addr", 32'(fail_addr), 0);
        if (extra_start) begin
            repeat (98) @(negedge clk);
            pulse_start();
        end
        got = 1'b0;
        for (int i = 0; i < RUN_CYCLES + 200 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        check("done_seen", 32'(got), 1);
        repeat (2) @(negedge clk);
        check("done_hold", 32'(done), 1);
        check("cs_low_in_done", 32'(mem_cs), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        clear_faults();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_no_done", 32'(done), 0);

        // Ideal RAM.
        run(1'b0);

        // Bit 0 of address 5 stuck at 1.
        clear_faults();
        or_m[5] = 8'h01;
        run(1'b0);

        // Every read returns zero.
        for (int i = 0; i < DEPTH; i++) and_m[i] = '0;
        run(1'b0);

        // Random faults, with a second start pulse that must be ignored.
        random_faults();
        run(1'b1);

        // More random fault sets.
        for (int k = 0; k < 2; k++) begin
            random_faults();
            run(1'b0);
        end

        // Reset during the pass-B read phase of a failing run, then a clean run.
        clear_faults();
        or_m[5] = 8'h01;
        pulse_start();
        repeat (5000) @(negedge clk);
        check("abort_busy", 32'(busy), 1);
        check("abort_in_read", 32'(mem_rd), 1);
        check("abort_err_seen", 32'(err_count), 1);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrun_reset");
        rst = 1'b0;
        clear_faults();
        run(1'b0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
